// File: rtl/dm_store_buffer_pkg.sv
// Shared definitions for the data-memory store buffer: store-type encodings,
// byte-enable constants and the layout of one queued store.
package dm_defs;

  localparam int DM_DEPTH = 4;
  localparam int DM_CNT_W = 3;

  typedef enum logic [1:0] {
    ST_SW  = 2'b00,
    ST_SH  = 2'b01,
    ST_SB  = 2'b10,
    ST_ILL = 2'b11
  } st_type_e;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] pc;
    logic [3:0]  byte_en;
  } st_entry_t;

endpackage

// File: rtl/dm_store_buffer_if.sv
// Bundle between the MEM stage / data memory and the store buffer.
interface dm_store_buffer_if #(parameter int CNT_W = 3);

  logic             st_valid;
  logic [1:0]       st_type;
  logic [31:0]      st_addr;
  logic [31:0]      st_data;
  logic [31:0]      st_pc;
  logic             st_ready;
  logic             st_err;
  logic             ld_valid;
  logic [31:0]      ld_addr;
  logic             ld_stall;
  logic             drain_hold;
  logic [31:0]      dm_addr;
  logic [31:0]      dm_wr_data;
  logic [31:0]      dm_pc;
  logic             dm_we;
  logic [3:0]       dm_byte_en;
  logic             empty;
  logic [CNT_W-1:0] count;

  modport master (
    output st_valid, st_type, st_addr, st_data, st_pc, ld_valid, ld_addr, drain_hold,
    input  st_ready, st_err, ld_stall, dm_addr, dm_wr_data, dm_pc, dm_we, dm_byte_en,
           empty, count
  );

  modport slave (
    input  st_valid, st_type, st_addr, st_data, st_pc, ld_valid, ld_addr, drain_hold,
    output st_ready, st_err, ld_stall, dm_addr, dm_wr_data, dm_pc, dm_we, dm_byte_en,
           empty, count
  );

endinterface

// File: rtl/dm_store_align.sv
// Turns a raw MEM-stage store into byte enables and low-aligned lane data,
// and flags misaligned or illegal stores (AdES).
module dm_store_align
  import dm_defs::*;
(
  input  logic        st_valid,
  input  logic [1:0]  st_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  output logic [3:0]  byte_en,
  output logic [31:0] lane_data,
  output logic        st_err
);

  logic misaligned;

  // Partial writes keep data in the low bits; the DM steers lanes from byte_en.
  always_comb begin
    byte_en    = 4'b0000;
    lane_data  = 32'h0;
    misaligned = 1'b0;
    case (st_type)
      ST_SW: begin
        byte_en    = BE_WORD;
        lane_data  = st_data;
        misaligned = (addr_lo != 2'b00);
      end
      ST_SH: begin
        byte_en    = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
        lane_data  = {16'h0, st_data[15:0]};
        misaligned = addr_lo[0];
      end
      ST_SB: begin
        byte_en   = 4'b0001 << addr_lo;
        lane_data = {24'h0, st_data[7:0]};
      end
      default: ;
    endcase
    st_err = st_valid & (misaligned | (st_type == ST_ILL));
  end

endmodule

// File: rtl/dm_store_buffer.sv
// Posted-write FIFO in front of the data memory: queues stores, drains one per
// cycle into the DM write port and stalls loads that hit a pending store word.
module dm_store_buffer
  import dm_defs::*;
#(
  parameter int DEPTH = DM_DEPTH,
  parameter int CNT_W = DM_CNT_W
) (
  input logic               clk,
  input logic               rst_n,
  dm_store_buffer_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);

  st_entry_t        entries [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;

  logic [3:0]  byte_en;
  logic [31:0] lane_data;
  logic        push;
  logic        pop;
  logic        unused_ld_lo;

  dm_store_align u_align (
    .st_valid  (bus.st_valid),
    .st_type   (bus.st_type),
    .addr_lo   (bus.st_addr[1:0]),
    .st_data   (bus.st_data),
    .byte_en   (byte_en),
    .lane_data (lane_data),
    .st_err    (bus.st_err)
  );

  // Full/empty come from the count alone; the pointers are equal in both cases.
  assign bus.empty    = (count_q == '0);
  assign bus.st_ready = (count_q != CNT_W'(DEPTH));
  assign bus.count    = count_q;
  assign bus.dm_we    = !bus.empty && !bus.drain_hold;

  assign push = bus.st_valid && bus.st_ready && !bus.st_err;
  assign pop  = bus.dm_we;

  assign bus.dm_addr    = bus.empty ? 32'h0 : entries[rd_ptr].addr;
  assign bus.dm_wr_data = bus.empty ? 32'h0 : entries[rd_ptr].data;
  assign bus.dm_pc      = bus.empty ? 32'h0 : entries[rd_ptr].pc;
  assign bus.dm_byte_en = bus.empty ? 4'h0  : entries[rd_ptr].byte_en;

  // The draining head still counts: the DM read this cycle sees the old word.
  always_comb begin
    bus.ld_stall = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (entries[i].addr[31:2] == bus.ld_addr[31:2])) begin
        bus.ld_stall = bus.ld_valid;
      end
    end
  end

  assign unused_ld_lo = ^bus.ld_addr[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
      valid   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        entries[wr_ptr] <= '{addr: bus.st_addr, data: lane_data, pc: bus.st_pc,
                             byte_en: byte_en};
        valid[wr_ptr]   <= 1'b1;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Directed bench for dm_store_buffer: alignment, drain order, full handling,
// load hazards and asynchronous reset mid-drain.
module tb_dm_store_buffer;
  import dm_defs::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  dm_store_buffer_if #(.CNT_W(3)) bus ();

  dm_store_buffer #(.DEPTH(4), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    assert (!(bus.st_valid && bus.ld_valid))
    else begin
      errors++;
      $error("FAIL st_ld_overlap: st_valid and ld_valid both high");
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] st_type, input logic [31:0] addr,
                                input logic [31:0] data, input logic [31:0] pc);
    bus.st_valid = 1'b1;
    bus.st_type  = st_type;
    bus.st_addr  = addr;
    bus.st_data  = data;
    bus.st_pc    = pc;
    #1;
  endtask

  task automatic idle();
    bus.st_valid = 1'b0;
    bus.ld_valid = 1'b0;
    #1;
  endtask

  task automatic load(input logic [31:0] addr);
    bus.st_valid = 1'b0;
    bus.ld_valid = 1'b1;
    bus.ld_addr  = addr;
    #1;
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst_n           = 1'b1;
    bus.st_valid    = 1'b0;
    bus.st_type     = ST_SW;
    bus.st_addr     = 32'h0;
    bus.st_data     = 32'h0;
    bus.st_pc       = 32'h0;
    bus.ld_valid    = 1'b0;
    bus.ld_addr     = 32'h0;
    bus.drain_hold  = 1'b0;
    #1 rst_n = 1'b0;
    #10;

    check_output("rst_count", 32'(bus.count), 32'd0);
    check_output("rst_empty", 32'(bus.empty), 32'd1);
    check_output("rst_ready", 32'(bus.st_ready), 32'd1);
    check_output("rst_we", 32'(bus.dm_we), 32'd0);
    check_output("rst_be", 32'(bus.dm_byte_en), 32'd0);
    check_output("rst_addr", bus.dm_addr, 32'h0);
    check_output("rst_stall", 32'(bus.ld_stall), 32'd0);
    rst_n = 1'b1;
    tick();

    // sw into an empty buffer appears on the DM port one edge later
    apply_stimulus(ST_SW, 32'h0000_0010, 32'h1234_5678, 32'h0000_0400);
    check_output("sw_err", 32'(bus.st_err), 32'd0);
    tick();
    idle();
    check_output("sw_we", 32'(bus.dm_we), 32'd1);
    check_output("sw_be", 32'(bus.dm_byte_en), 32'hF);
    check_output("sw_addr", bus.dm_addr, 32'h0000_0010);
    check_output("sw_data", bus.dm_wr_data, 32'h1234_5678);
    check_output("sw_pc", bus.dm_pc, 32'h0000_0400);
    check_output("sw_count", 32'(bus.count), 32'd1);
    tick();
    check_output("sw_empty", 32'(bus.empty), 32'd1);
    check_output("sw_we_off", 32'(bus.dm_we), 32'd0);
    check_output("sw_addr_zero", bus.dm_addr, 32'h0);

    // byte and halfword lanes
    apply_stimulus(ST_SB, 32'h0000_0013, 32'hCAFE_12AB, 32'h0000_0404);
    tick();
    idle();
    check_output("sb_be", 32'(bus.dm_byte_en), 32'h8);
    check_output("sb_data", bus.dm_wr_data, 32'h0000_00AB);
    check_output("sb_addr", bus.dm_addr, 32'h0000_0013);
    tick();
    apply_stimulus(ST_SH, 32'h0000_0022, 32'h1234_BEEF, 32'h0000_0408);
    tick();
    idle();
    check_output("sh_hi_be", 32'(bus.dm_byte_en), 32'hC);
    check_output("sh_hi_data", bus.dm_wr_data, 32'h0000_BEEF);
    tick();
    apply_stimulus(ST_SH, 32'h0000_0020, 32'h1234_BEEF, 32'h0000_040C);
    tick();
    idle();
    check_output("sh_lo_be", 32'(bus.dm_byte_en), 32'h3);
    tick();
    apply_stimulus(ST_SB, 32'h0000_0011, 32'h0000_0077, 32'h0000_0410);
    tick();
    idle();
    check_output("sb1_be", 32'(bus.dm_byte_en), 32'h2);
    check_output("sb1_data", bus.dm_wr_data, 32'h0000_0077);
    tick();

    // fill under drain_hold, refuse a fifth store, then drain in order
    bus.drain_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(ST_SW, 32'h0000_0100 + 32'(4 * i), 32'h0000_00A0 + 32'(i), 32'h0000_0500);
      tick();
    end
    check_output("full_count", 32'(bus.count), 32'd4);
    check_output("full_ready", 32'(bus.st_ready), 32'd0);
    check_output("full_we_held", 32'(bus.dm_we), 32'd0);
    check_output("full_head", bus.dm_addr, 32'h0000_0100);
    apply_stimulus(ST_SW, 32'h0000_0110, 32'h0000_00A4, 32'h0000_0500);
    tick();
    check_output("full_5th", 32'(bus.count), 32'd4);
    idle();
    bus.drain_hold = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check_output("drain_we", 32'(bus.dm_we), 32'd1);
      check_output("drain_addr", bus.dm_addr, 32'h0000_0100 + 32'(4 * i));
      check_output("drain_data", bus.dm_wr_data, 32'h0000_00A0 + 32'(i));
      tick();
    end
    check_output("drain_count", 32'(bus.count), 32'd0);
    check_output("drain_empty", 32'(bus.empty), 32'd1);

    // load hazards against a pending word
    bus.drain_hold = 1'b1;
    apply_stimulus(ST_SW, 32'h0000_0040, 32'h0000_0055, 32'h0000_0600);
    tick();
    load(32'h0000_0042);
    check_output("haz_hit", 32'(bus.ld_stall), 32'd1);
    load(32'h0000_0044);
    check_output("haz_miss", 32'(bus.ld_stall), 32'd0);
    idle();
    bus.ld_addr = 32'h0000_0042;
    #1;
    check_output("haz_no_valid", 32'(bus.ld_stall), 32'd0);

    // push while the head pops: count stays put, queue advances
    bus.drain_hold = 1'b0;
    apply_stimulus(ST_SW, 32'h0000_0080, 32'h0000_0077, 32'h0000_0604);
    check_output("pp_we", 32'(bus.dm_we), 32'd1);
    tick();
    load(32'h0000_0082);
    check_output("pp_count", 32'(bus.count), 32'd1);
    check_output("pp_head", bus.dm_addr, 32'h0000_0080);
    check_output("haz_draining_head", 32'(bus.ld_stall), 32'd1);
    tick();
    check_output("haz_after_drain", 32'(bus.ld_stall), 32'd0);
    load(32'h0000_0042);
    check_output("haz_old_gone", 32'(bus.ld_stall), 32'd0);
    idle();

    // misaligned and illegal stores are rejected
    apply_stimulus(ST_SH, 32'h0000_0021, 32'h0000_1111, 32'h0000_0700);
    check_output("err_sh", 32'(bus.st_err), 32'd1);
    tick();
    apply_stimulus(ST_SW, 32'h0000_0006, 32'h0000_2222, 32'h0000_0704);
    check_output("err_sw", 32'(bus.st_err), 32'd1);
    tick();
    apply_stimulus(ST_ILL, 32'h0000_0000, 32'h0000_3333, 32'h0000_0708);
    check_output("err_ill", 32'(bus.st_err), 32'd1);
    tick();
    check_output("err_count", 32'(bus.count), 32'd0);
    check_output("err_we", 32'(bus.dm_we), 32'd0);
    idle();
    check_output("err_idle", 32'(bus.st_err), 32'd0);

    // asynchronous reset in the middle of a drain
    bus.drain_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(ST_SW, 32'h0000_0200 + 32'(4 * i), 32'h0000_00C0 + 32'(i), 32'h0000_0800);
      tick();
    end
    idle();
    check_output("rd_count", 32'(bus.count), 32'd3);
    bus.drain_hold = 1'b0;
    tick();
    check_output("rd_we_before", 32'(bus.dm_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_output("rd_we_cut", 32'(bus.dm_we), 32'd0);
    check_output("rd_empty", 32'(bus.empty), 32'd1);
    check_output("rd_count0", 32'(bus.count), 32'd0);
    tick();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_output("rd_no_write", 32'(bus.dm_we), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
